// File: rtl/uart_pixel_loader_if.sv
// Framebuffer write-request channel: one pixel (x, y, RGB) per valid/ready handshake.
interface uart_pixel_loader_if #(
   parameter int X_BITS = 11,
   parameter int Y_BITS = 10
);
   logic              wr_valid;
   logic              wr_ready;
   logic [X_BITS-1:0] wr_x;
   logic [Y_BITS-1:0] wr_y;
   logic [23:0]       wr_rgb;

   modport master (output wr_valid, wr_x, wr_y, wr_rgb, input wr_ready);
   modport slave  (input wr_valid, wr_x, wr_y, wr_rgb, output wr_ready);
endinterface

// File: rtl/uart_pixel_loader.sv
// 8N1 serial receiver plus pixel-packet parser feeding a single-entry write register
// towards the frame-buffer video generator.
module uart_pixel_loader #(
   parameter int CLK_HZ  = 74250000,
   parameter int BAUD    = 115200,
   parameter int X_BITS  = 11,
   parameter int Y_BITS  = 10,
   parameter int FRAME_W = 1280,
   parameter int FRAME_H = 720
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rxd,
   uart_pixel_loader_if.master wr,
   output logic                overrun,
   output logic                frame_err,
   output logic                busy
);

   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

   localparam logic [2:0] R_IDLE  = 3'd0;
   localparam logic [2:0] R_START = 3'd1;
   localparam logic [2:0] R_DATA  = 3'd2;
   localparam logic [2:0] R_STOP  = 3'd3;
   localparam logic [2:0] R_WAIT  = 3'd4;

   localparam logic [3:0] S_SYNC = 4'd0;
   localparam logic [3:0] S_XL   = 4'd1;
   localparam logic [3:0] S_XH   = 4'd2;
   localparam logic [3:0] S_YL   = 4'd3;
   localparam logic [3:0] S_YH   = 4'd4;
   localparam logic [3:0] S_CNT  = 4'd5;
   localparam logic [3:0] S_R    = 4'd6;
   localparam logic [3:0] S_G    = 4'd7;
   localparam logic [3:0] S_B    = 4'd8;

   // Synchroniser and edge detector; reset to idle-high so reset never looks like a start bit.
   logic rx_meta_q, rxs_q, rxs_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_meta_q  <= rxd;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   logic [2:0]    rx_state_q, rx_state_d;
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          byte_stb_q, byte_stb_d;
   logic          frame_err_q, frame_err_d;

   always_comb begin
      rx_state_d  = rx_state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      byte_stb_d  = 1'b0;
      frame_err_d = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               baud_cnt_d = HALF_M1;
               rx_state_d = R_START;
            end
         end
         R_START: begin
            if (baud_cnt_q == '0) begin
               if (rxs_q) begin
                  rx_state_d = R_IDLE;
               end else begin
                  baud_cnt_d = FULL_M1;
                  bit_idx_d  = 3'd0;
                  rx_state_d = R_DATA;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         R_DATA: begin
            if (baud_cnt_q == '0) begin
               shreg_d    = {rxs_q, shreg_q[7:1]};
               baud_cnt_d = FULL_M1;
               if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
               else                   bit_idx_d  = bit_idx_q + 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         R_STOP: begin
            if (baud_cnt_q == '0) begin
               if (rxs_q) begin
                  byte_stb_d = 1'b1;
                  rx_state_d = R_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  rx_state_d  = R_WAIT;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         R_WAIT: begin
            if (rxs_q) rx_state_d = R_IDLE;
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q  <= R_IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'd0;
         byte_stb_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         byte_stb_q  <= byte_stb_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Parser: shreg_q holds the delivered byte while byte_stb_q is high.
   logic [3:0]        state_q, state_d;
   logic [7:0]        xl_q, xl_d, yl_q, yl_d, r_q, r_d, g_q, g_d;
   logic [X_BITS-1:0] x_q, x_d;
   logic [Y_BITS-1:0] y_q, y_d;
   logic [8:0]        pix_cnt_q, pix_cnt_d;
   logic [X_BITS:0]   x_inc;
   logic [Y_BITS:0]   y_inc;
   logic              emit;

   assign x_inc = {1'b0, x_q} + 1'b1;
   assign y_inc = {1'b0, y_q} + 1'b1;
   assign emit  = byte_stb_q && (state_q == S_B);

   always_comb begin
      state_d   = state_q;
      xl_d      = xl_q;
      yl_d      = yl_q;
      r_d       = r_q;
      g_d       = g_q;
      x_d       = x_q;
      y_d       = y_q;
      pix_cnt_d = pix_cnt_q;
      if (frame_err_q) begin
         state_d = S_SYNC;
      end else if (byte_stb_q) begin
         case (state_q)
            S_SYNC: if (shreg_q == 8'hA5) state_d = S_XL;
            S_XL: begin
               xl_d    = shreg_q;
               state_d = S_XH;
            end
            S_XH: begin
               x_d     = X_BITS'({shreg_q, xl_q});
               state_d = S_YL;
            end
            S_YL: begin
               yl_d    = shreg_q;
               state_d = S_YH;
            end
            S_YH: begin
               y_d     = Y_BITS'({shreg_q, yl_q});
               state_d = S_CNT;
            end
            S_CNT: begin
               pix_cnt_d = {1'b0, shreg_q} + 9'd1;
               state_d   = S_R;
            end
            S_R: begin
               r_d     = shreg_q;
               state_d = S_G;
            end
            S_G: begin
               g_d     = shreg_q;
               state_d = S_B;
            end
            S_B: begin
               pix_cnt_d = pix_cnt_q - 9'd1;
               state_d   = (pix_cnt_q != 9'd1) ? S_R : S_SYNC;
               // Wrap only on exact equality so out-of-frame start coordinates pass through.
               if (x_inc == (X_BITS+1)'(FRAME_W)) begin
                  x_d = '0;
                  if (y_inc == (Y_BITS+1)'(FRAME_H)) y_d = '0;
                  else                               y_d = y_inc[Y_BITS-1:0];
               end else begin
                  x_d = x_inc[X_BITS-1:0];
               end
            end
            default: state_d = S_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_SYNC;
         xl_q      <= 8'd0;
         yl_q      <= 8'd0;
         r_q       <= 8'd0;
         g_q       <= 8'd0;
         x_q       <= '0;
         y_q       <= '0;
         pix_cnt_q <= 9'd0;
      end else begin
         state_q   <= state_d;
         xl_q      <= xl_d;
         yl_q      <= yl_d;
         r_q       <= r_d;
         g_q       <= g_d;
         x_q       <= x_d;
         y_q       <= y_d;
         pix_cnt_q <= pix_cnt_d;
      end
   end

   // Single-entry output register; a same-cycle handshake frees the slot for the new pixel.
   logic              wr_valid_q, wr_valid_d;
   logic [X_BITS-1:0] wr_x_q, wr_x_d;
   logic [Y_BITS-1:0] wr_y_q, wr_y_d;
   logic [23:0]       wr_rgb_q, wr_rgb_d;
   logic              overrun_q, overrun_d;

   always_comb begin
      wr_valid_d = wr_valid_q;
      wr_x_d     = wr_x_q;
      wr_y_d     = wr_y_q;
      wr_rgb_d   = wr_rgb_q;
      overrun_d  = 1'b0;
      if (emit) begin
         if (!wr_valid_q || wr.wr_ready) begin
            wr_valid_d = 1'b1;
            wr_x_d     = x_q;
            wr_y_d     = y_q;
            wr_rgb_d   = {r_q, g_q, shreg_q};
         end else begin
            overrun_d = 1'b1;
         end
      end else if (wr_valid_q && wr.wr_ready) begin
         wr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_valid_q <= 1'b0;
         wr_x_q     <= '0;
         wr_y_q     <= '0;
         wr_rgb_q   <= 24'd0;
         overrun_q  <= 1'b0;
      end else begin
         wr_valid_q <= wr_valid_d;
         wr_x_q     <= wr_x_d;
         wr_y_q     <= wr_y_d;
         wr_rgb_q   <= wr_rgb_d;
         overrun_q  <= overrun_d;
      end
   end

   assign wr.wr_valid = wr_valid_q;
   assign wr.wr_x     = wr_x_q;
   assign wr.wr_y     = wr_y_q;
   assign wr.wr_rgb   = wr_rgb_q;
   assign overrun     = overrun_q;
   assign frame_err   = frame_err_q;
   assign busy        = (state_q != S_SYNC);

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Serial-stream bench for uart_pixel_loader: table vectors, hand sequences for
// wrap/backpressure/framing/noise/reset, then random packets against a pixel-list model.
`timescale 1ns/1ps
module tb_uart_pixel_loader;
   localparam int DIV = 16;

   logic clk = 1'b0;
   logic rst;
   logic rxd;
   logic overrun, frame_err, busy;

   always #5 clk = ~clk;

   uart_pixel_loader_if #(.X_BITS(11), .Y_BITS(10)) wr_if ();

   uart_pixel_loader #(
      .CLK_HZ(16), .BAUD(1), .X_BITS(11), .Y_BITS(10), .FRAME_W(1280), .FRAME_H(720)
   ) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .wr(wr_if),
      .overrun(overrun), .frame_err(frame_err), .busy(busy)
   );

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic [23:0] rgb;
   } pix_t;

   typedef struct {
      logic [15:0] xw;
      logic [15:0] yw;
      logic [23:0] rgb;
      logic [10:0] ex;
      logic [9:0]  ey;
   } vec_t;

   pix_t exp_q[$];
   int   vecs = 0, errs = 0;
   int   writes = 0, ovr_cnt = 0, fe_cnt = 0, long_pulses = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor on the falling edge: handshakes, hold stability, pulse widths.
   logic        prev_hold = 1'b0, ovr_prev = 1'b0, fe_prev = 1'b0;
   pix_t        held;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            vecs++;
            if (!wr_if.wr_valid || wr_if.wr_x !== held.x || wr_if.wr_y !== held.y ||
                wr_if.wr_rgb !== held.rgb) begin
               errs++;
               $display("FAIL hold: got v=%0b x=%0d y=%0d rgb=%06h expected v=1 x=%0d y=%0d rgb=%06h",
                        wr_if.wr_valid, wr_if.wr_x, wr_if.wr_y, wr_if.wr_rgb, held.x, held.y, held.rgb);
            end
         end
         if (wr_if.wr_valid && wr_if.wr_ready) begin
            pix_t e;
            writes++;
            vecs++;
            if (exp_q.size() == 0) begin
               errs++;
               $display("FAIL write: unexpected x=%0d y=%0d rgb=%06h, none expected",
                        wr_if.wr_x, wr_if.wr_y, wr_if.wr_rgb);
            end else begin
               e = exp_q.pop_front();
               if (wr_if.wr_x !== e.x || wr_if.wr_y !== e.y || wr_if.wr_rgb !== e.rgb) begin
                  errs++;
                  $display("FAIL write: got x=%0d y=%0d rgb=%06h expected x=%0d y=%0d rgb=%06h",
                           wr_if.wr_x, wr_if.wr_y, wr_if.wr_rgb, e.x, e.y, e.rgb);
               end else begin
                  $display("write x=%0d y=%0d rgb=%06h", e.x, e.y, e.rgb);
               end
            end
         end
         prev_hold = wr_if.wr_valid && !wr_if.wr_ready;
         held.x    = wr_if.wr_x;
         held.y    = wr_if.wr_y;
         held.rgb  = wr_if.wr_rgb;
         if (overrun) begin
            ovr_cnt++;
            if (ovr_prev) long_pulses++;
         end
         if (frame_err) begin
            fe_cnt++;
            if (fe_prev) long_pulses++;
         end
         ovr_prev = overrun;
         fe_prev  = frame_err;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(DIV);
      end
      rxd = stop_bit;
      tick(DIV);
      rxd = 1'b1;
   endtask

   task automatic send_raw(input logic [15:0] xw, input logic [15:0] yw, input logic [23:0] cols[$]);
      logic [7:0] n;
      n = 8'(cols.size() - 1);
      send_byte(8'hA5, 1'b1);
      send_byte(xw[7:0], 1'b1);
      send_byte(xw[15:8], 1'b1);
      send_byte(yw[7:0], 1'b1);
      send_byte(yw[15:8], 1'b1);
      send_byte(n, 1'b1);
      foreach (cols[k]) begin
         send_byte(cols[k][23:16], 1'b1);
         send_byte(cols[k][15:8], 1'b1);
         send_byte(cols[k][7:0], 1'b1);
      end
   endtask

   // Reference: pixels walk raster order from the start point, wrapping at the frame edge.
   task automatic model_pkt(input logic [15:0] xw, input logic [15:0] yw, input logic [23:0] cols[$]);
      int   x, y;
      pix_t p;
      x = xw % 2048;
      y = yw % 1024;
      foreach (cols[k]) begin
         p.x   = 11'(x);
         p.y   = 10'(y);
         p.rgb = cols[k];
         exp_q.push_back(p);
         x = x + 1;
         if (x == 1280) begin
            x = 0;
            y = y + 1;
            if (y == 720) y = 0;
         end
         x = x % 2048;
         y = y % 1024;
      end
   endtask

   task automatic run_pkt(input logic [15:0] xw, input logic [15:0] yw, input logic [23:0] cols[$]);
      model_pkt(xw, yw, cols);
      send_raw(xw, yw, cols);
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         tick(1);
         t++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   function automatic logic [15:0] rand_coord(input int lim, input int bits);
      int v;
      case ($urandom_range(0, 3))
         0:       v = $urandom_range(0, lim - 1);
         1:       v = lim - 1;
         2:       v = lim - 2;
         default: v = $urandom_range(0, (1 << bits) - 1);
      endcase
      return 16'(v | ($urandom_range(0, 255) << bits));
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[6];
      logic [23:0] cols[$];
      pix_t        p;
      int          w0, o0, f0;

      tbl[0] = '{16'h0005, 16'h0003, 24'h112233, 11'd5,    10'd3};
      tbl[1] = '{16'h1234, 16'h5678, 24'hABCDEF, 11'h234,  10'h278};
      tbl[2] = '{16'hFFFF, 16'hFFFF, 24'h000000, 11'd2047, 10'd1023};
      tbl[3] = '{16'h04FF, 16'h02CF, 24'hFFFFFF, 11'd1279, 10'd719};
      tbl[4] = '{16'h0000, 16'h0000, 24'h5A5A5A, 11'd0,    10'd0};
      tbl[5] = '{16'h0500, 16'h02D0, 24'h010203, 11'd1280, 10'd720};

      rst = 1'b1;
      rxd = 1'b1;
      wr_if.wr_ready = 1'b1;
      tick(5);
      check("rst_valid", 64'(wr_if.wr_valid), 64'd0);
      check("rst_x", 64'(wr_if.wr_x), 64'd0);
      check("rst_y", 64'(wr_if.wr_y), 64'd0);
      check("rst_rgb", 64'(wr_if.wr_rgb), 64'd0);
      check("rst_pulses", 64'({overrun, frame_err}), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick(5);

      for (int i = 0; i < 6; i++) begin
         p.x = tbl[i].ex;
         p.y = tbl[i].ey;
         p.rgb = tbl[i].rgb;
         exp_q.push_back(p);
         cols = '{tbl[i].rgb};
         send_raw(tbl[i].xw, tbl[i].yw, cols);
         tick(5);
         check($sformatf("tbl%0d_busy", i), 64'(busy), 64'd0);
         wait_drain($sformatf("tbl%0d_drain", i));
      end

      // Wrap from the last pixel of the frame back to the origin.
      p = '{11'd1279, 10'd719, 24'hC0FFEE};
      exp_q.push_back(p);
      p = '{11'd0, 10'd0, 24'h123456};
      exp_q.push_back(p);
      cols = '{24'hC0FFEE, 24'h123456};
      send_raw(16'd1279, 16'd719, cols);
      wait_drain("wrap_drain");

      // Backpressure: second pixel is dropped while the first is held.
      w0 = writes;
      o0 = ovr_cnt;
      wr_if.wr_ready = 1'b0;
      p = '{11'd10, 10'd20, 24'hAA0001};
      exp_q.push_back(p);
      cols = '{24'hAA0001, 24'hBB0002};
      send_raw(16'd10, 16'd20, cols);
      tick(10);
      check("bp_valid", 64'(wr_if.wr_valid), 64'd1);
      check("bp_x", 64'(wr_if.wr_x), 64'd10);
      check("bp_rgb", 64'(wr_if.wr_rgb), 64'hAA0001);
      check("bp_overrun", 64'(ovr_cnt - o0), 64'd1);
      wr_if.wr_ready = 1'b1;
      tick(10);
      wait_drain("bp_drain");
      check("bp_writes", 64'(writes - w0), 64'd1);
      check("bp_valid_clr", 64'(wr_if.wr_valid), 64'd0);

      // Framing error on the YL byte.
      f0 = fe_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h07, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h09, 1'b0);
      tick(40);
      check("fe_count", 64'(fe_cnt - f0), 64'd1);
      check("fe_busy", 64'(busy), 64'd0);
      check("fe_valid", 64'(wr_if.wr_valid), 64'd0);
      cols = '{24'h102030};
      run_pkt(16'd100, 16'd200, cols);
      wait_drain("fe_next_pkt");

      // Idle glitch, then junk bytes before a real packet.
      w0 = writes;
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(40);
      check("glitch_busy", 64'(busy), 64'd0);
      check("glitch_writes", 64'(writes - w0), 64'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      tick(4);
      check("junk_busy", 64'(busy), 64'd0);
      cols = '{24'h0F0E0D, 24'h0C0B0A};
      run_pkt(16'd640, 16'd360, cols);
      wait_drain("junk_next_pkt");

      // Reset after the G byte of a packet.
      w0 = writes;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h77, 1'b1);
      send_byte(8'h88, 1'b1);
      rst = 1'b1;
      tick(2);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_valid", 64'(wr_if.wr_valid), 64'd0);
      rst = 1'b0;
      tick(3);
      cols = '{24'h99AABB};
      run_pkt(16'd3, 16'd4, cols);
      wait_drain("rst_next_pkt");
      check("rst_writes", 64'(writes - w0), 64'd1);

      // Random packets against the model.
      for (int i = 0; i < 12; i++) begin
         int nc;
         logic [15:0] xw, yw;
         nc = $urandom_range(1, 3);
         xw = rand_coord(1280, 11);
         yw = rand_coord(720, 10);
         cols.delete();
         for (int k = 0; k < nc; k++) cols.push_back(24'($urandom));
         run_pkt(xw, yw, cols);
         wait_drain($sformatf("rand%0d_drain", i));
      end

      check("total_overruns", 64'(ovr_cnt), 64'd1);
      check("total_frame_errs", 64'(fe_cnt), 64'd1);
      check("pulse_width", 64'(long_pulses), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
- Receives a byte stream on the serial input and decodes pixel-write packets.
- Emits one framebuffer write request (x, y, 24-bit RGB) per decoded pixel through a valid/ready handshake to the 720p frame-buffer video generator, which commits the writes to SDRAM.
- Sits between the board's rxd pin and the video generator, in the pixel clock domain.

Parameters:
CLK_HZ, 74250000, clock frequency in Hz
BAUD, 115200, serial bit rate
X_BITS, 11, width of x coordinate
Y_BITS, 10, width of y coordinate
FRAME_W, 1280, x wrap limit
FRAME_H, 720, y wrap limit

Ports:
clk  in  1  pixel clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
rxd  in  1  asynchronous serial input, 8N1, idle high
wr_valid  out  1  write request pending
wr_ready  in  1  consumer accepts the request when wr_valid && wr_ready
wr_x  out  X_BITS  pixel x
wr_y  out  Y_BITS  pixel y
wr_rgb  out  24  {R,G,B}
overrun  out  1  one-cycle pulse: a pixel was dropped
frame_err  out  1  one-cycle pulse: stop bit sampled low
busy  out  1  parser not in S_SYNC

Behaviour:
- Reset (synchronous, active-high): all outputs 0; the parser returns to S_SYNC and the receiver to idle. A pending request is discarded. Reset wins over every other event in the same cycle, including mid-byte and mid-packet.
- rxd synchronisation: two-flop synchroniser; its output is rxs, and 2 cycles of input latency are expected.
- Bit timing: DIV = (CLK_HZ + BAUD/2) / BAUD, computed at elaboration.
- Receiver:
  - Start: a falling edge on rxs starts a half-DIV countdown (DIV/2 cycles).
  - Start validation: if rxs is high at the half-bit point, it is a false start and the receiver returns to idle silently.
  - Data: 8 data bits are sampled, LSB first, every DIV cycles.
  - Stop: the stop bit is sampled one DIV later. If it is high, byte_stb pulses for 1 cycle with the byte. If it is low, frame_err pulses, no byte is delivered, the parser is forced to S_SYNC, and the receiver waits for rxs high before re-arming.
- Packet format: 0xA5, XL, XH, YL, YH, N, then N+1 triples R,G,B.
  - x = {XH,XL}[X_BITS-1:0] and y = {YH,YL}[Y_BITS-1:0]; upper bits are ignored.
- Parser states: S_SYNC → S_XL → S_XH → S_YL → S_YH → S_CNT → S_R → S_G → S_B.
  - In S_SYNC, any byte other than 0xA5 is discarded.
  - In S_CNT, the remaining count is loaded as N+1 (9-bit).
  - After S_B, the pixel is emitted, the count is decremented, and the parser returns to S_R if the count is nonzero, otherwise to S_SYNC.
- Coordinate advance (after each emitted pixel):
  - x+1; if x+1 == FRAME_W, x wraps to 0 and y advances.
  - If y+1 == FRAME_H, y wraps to 0.
  - Coordinates received at or beyond FRAME_W/FRAME_H are passed through unmodified for the first pixel; the wrap compare is equality on the incremented value only.
- Output register (single entry):
  - On B-byte completion with wr_valid == 0, wr_x/wr_y/wr_rgb load and wr_valid goes to 1 on the next cycle.
  - wr_valid stays high with outputs stable until a cycle in which wr_ready is 1; wr_valid clears the cycle after.
  - If a B byte completes while wr_valid == 1 and wr_ready == 0 in that cycle: the new pixel is dropped, overrun pulses, and coordinates still advance.
  - If wr_ready == 1 in that same cycle, the handshake completes and the new pixel loads, with no overrun. wr_valid stays high continuously.
- Latency: the first wr_valid comes 1 cycle after byte_stb of the B byte.
- busy: combinational from the state register.

Test Plan:
- Bench parameters: CLK_HZ=16, BAUD=1 (DIV=16).
- Single pixel: send A5,05,00,03,00,00,11,22,33 with wr_ready=1 → one handshake with wr_x=5, wr_y=3, wr_rgb=0x112233; busy falls after the B byte.
- Wrap: header x=1279, y=719, N=1, two RGB triples → handshakes at (1279,719) then (0,0).
- Backpressure: wr_ready held 0 for the whole of the second pixel of an N=1 packet → first pixel stays stable, overrun pulses once, and only 1 write occurs after wr_ready rises.
- Framing error: stop bit driven low during the YL byte → frame_err pulses 1 cycle and busy=0; a following valid packet decodes correctly.
- Noise: 3-cycle low glitch on rxd while idle → no byte, no outputs change. Bytes 00,FF before A5 are ignored.
- Reset mid-packet: assert rst after the G byte, then send a full packet → no write from the aborted packet; the new packet decodes correctly.
